// File: rtl/mqnic_tx_scheduler_block_wrr.sv
// Weighted round-robin TX scheduler block: tracks active queues, issues tagged TX
// requests bounded by an op table, and exposes config/status through a register block.
module mqnic_tx_scheduler_block_wrr #(
  parameter int PORTS = 1,
  parameter int INDEX = 0,
  parameter int QUEUE_INDEX_WIDTH = 3,
  parameter int WEIGHT_WIDTH = 4,
  parameter int OP_TABLE_SIZE = 8,
  parameter int TX_REQ_TAG_WIDTH = 8,
  parameter int AXIS_TX_DEST_WIDTH = $clog2(PORTS)+4,
  parameter int REG_ADDR_WIDTH = 16,
  parameter int REG_DATA_WIDTH = 32,
  parameter int REG_STRB_WIDTH = REG_DATA_WIDTH/8,
  parameter int RB_BASE_ADDR = 0,
  parameter int RB_NEXT_PTR = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [REG_ADDR_WIDTH-1:0]     ctrl_reg_wr_addr,
  input  logic [REG_DATA_WIDTH-1:0]     ctrl_reg_wr_data,
  input  logic [REG_STRB_WIDTH-1:0]     ctrl_reg_wr_strb,
  input  logic                          ctrl_reg_wr_en,
  output logic                          ctrl_reg_wr_wait,
  output logic                          ctrl_reg_wr_ack,
  input  logic [REG_ADDR_WIDTH-1:0]     ctrl_reg_rd_addr,
  input  logic                          ctrl_reg_rd_en,
  output logic [REG_DATA_WIDTH-1:0]     ctrl_reg_rd_data,
  output logic                          ctrl_reg_rd_wait,
  output logic                          ctrl_reg_rd_ack,
  output logic [QUEUE_INDEX_WIDTH-1:0]  m_axis_tx_req_queue,
  output logic [TX_REQ_TAG_WIDTH-1:0]   m_axis_tx_req_tag,
  output logic [AXIS_TX_DEST_WIDTH-1:0] m_axis_tx_req_dest,
  output logic                          m_axis_tx_req_valid,
  input  logic                          m_axis_tx_req_ready,
  input  logic                          s_axis_tx_status_dequeue_empty,
  input  logic                          s_axis_tx_status_dequeue_error,
  input  logic [TX_REQ_TAG_WIDTH-1:0]   s_axis_tx_status_dequeue_tag,
  input  logic                          s_axis_tx_status_dequeue_valid,
  input  logic [TX_REQ_TAG_WIDTH-1:0]   s_axis_tx_status_finish_tag,
  input  logic                          s_axis_tx_status_finish_valid,
  input  logic [QUEUE_INDEX_WIDTH-1:0]  s_axis_doorbell_queue,
  input  logic                          s_axis_doorbell_valid,
  output logic                          active
);
  localparam int QUEUE_COUNT = 2**QUEUE_INDEX_WIDTH;
  localparam int OP_W = $clog2(OP_TABLE_SIZE);
  localparam int CNT_W = $clog2(OP_TABLE_SIZE+1);
  localparam logic [AXIS_TX_DEST_WIDTH-1:0] DEST_RST = AXIS_TX_DEST_WIDTH'((INDEX % PORTS) << 4);

  logic                          wr_ack_reg, rd_ack_reg, enable_reg;
  logic [REG_DATA_WIDTH-1:0]     rd_data_reg;
  logic [AXIS_TX_DEST_WIDTH-1:0] dest_reg;
  logic [WEIGHT_WIDTH-1:0]       weight_reg [QUEUE_COUNT];
  logic [QUEUE_COUNT-1:0]        qen_reg, active_reg, doorbell_seen;
  logic [OP_TABLE_SIZE-1:0]      op_valid;
  logic [QUEUE_INDEX_WIDTH-1:0]  op_queue [OP_TABLE_SIZE];
  logic [QUEUE_INDEX_WIDTH-1:0]  rr_ptr, req_queue, sel_q;
  logic [WEIGHT_WIDTH-1:0]       credit, sel_weight;
  logic [TX_REQ_TAG_WIDTH-1:0]   req_tag;
  logic                          req_valid, issue, load_credit, free_found;
  logic [OP_W-1:0]               free_idx, deq_slot, fin_slot;
  logic [CNT_W-1:0]              outstanding;
  logic [QUEUE_COUNT-1:0]        eligible;
  logic                          deq_rel, deq_clr, fin_rel;
  logic [QUEUE_INDEX_WIDTH-1:0]  deq_q;

  assign ctrl_reg_wr_wait    = 1'b0;
  assign ctrl_reg_rd_wait    = 1'b0;
  assign ctrl_reg_wr_ack     = wr_ack_reg;
  assign ctrl_reg_rd_ack     = rd_ack_reg;
  assign ctrl_reg_rd_data    = rd_data_reg;
  assign m_axis_tx_req_queue = req_queue;
  assign m_axis_tx_req_tag   = req_tag;
  assign m_axis_tx_req_dest  = dest_reg;
  assign m_axis_tx_req_valid = req_valid;

  logic unused_bits;
  assign unused_bits = ^{ctrl_reg_wr_data, ctrl_reg_wr_strb, ctrl_reg_wr_addr[1:0], ctrl_reg_rd_addr[1:0]};

  // Register address decode, offsets relative to the block base
  logic [REG_ADDR_WIDTH-1:0]    rd_off, wr_off;
  logic [QUEUE_INDEX_WIDTH-1:0] rd_qi, wr_qi;
  logic                         rd_is_q, wr_is_q, rd_hit, wr_hit;
  logic [31:0]                  rd_val;

  assign rd_off  = {ctrl_reg_rd_addr[REG_ADDR_WIDTH-1:2], 2'b00} - REG_ADDR_WIDTH'(RB_BASE_ADDR);
  assign wr_off  = {ctrl_reg_wr_addr[REG_ADDR_WIDTH-1:2], 2'b00} - REG_ADDR_WIDTH'(RB_BASE_ADDR);
  assign rd_is_q = (32'(rd_off) >= 32'h40) && (32'(rd_off) < 32'(32'h40 + 4*QUEUE_COUNT));
  assign wr_is_q = (32'(wr_off) >= 32'h40) && (32'(wr_off) < 32'(32'h40 + 4*QUEUE_COUNT));
  assign rd_qi   = rd_off[QUEUE_INDEX_WIDTH+1:2];
  assign wr_qi   = wr_off[QUEUE_INDEX_WIDTH+1:2];
  assign wr_hit  = (32'(wr_off) == 32'h20) || (32'(wr_off) == 32'h24) || wr_is_q;

  always_comb begin
    rd_hit = 1'b1;
    rd_val = '0;
    case (32'(rd_off))
      32'h00: rd_val = 32'h0000_C004;
      32'h04: rd_val = 32'h0000_0400;
      32'h08: rd_val = 32'(RB_NEXT_PTR);
      32'h0C: rd_val = 32'(RB_BASE_ADDR + 32'h10);
      32'h10: rd_val = 32'h0000_C041;
      32'h14: rd_val = 32'h0000_0100;
      32'h18: rd_val = 32'h0;
      32'h1C: rd_val = 32'(QUEUE_COUNT);
      32'h20: rd_val = 32'(enable_reg);
      32'h24: rd_val = 32'(dest_reg);
      32'h28: rd_val = 32'(outstanding);
      32'h2C: rd_val = 32'(active_reg);
      default: begin
        if (rd_is_q)
          rd_val = 32'(weight_reg[rd_qi]) | (32'(qen_reg[rd_qi]) << 16) | (32'(active_reg[rd_qi]) << 24);
        else
          rd_hit = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ack_reg  <= 1'b0;
      rd_ack_reg  <= 1'b0;
      rd_data_reg <= '0;
      enable_reg  <= 1'b0;
      dest_reg    <= DEST_RST;
      qen_reg     <= '1;
      for (int i = 0; i < QUEUE_COUNT; i++) weight_reg[i] <= WEIGHT_WIDTH'(1);
    end else begin
      wr_ack_reg <= 1'b0;
      rd_ack_reg <= 1'b0;
      if (ctrl_reg_wr_en && !wr_ack_reg && wr_hit) begin
        wr_ack_reg <= 1'b1;
        if (32'(wr_off) == 32'h20 && ctrl_reg_wr_strb[0]) enable_reg <= ctrl_reg_wr_data[0];
        if (32'(wr_off) == 32'h24 && ctrl_reg_wr_strb[0]) dest_reg <= AXIS_TX_DEST_WIDTH'(ctrl_reg_wr_data[7:0]);
        if (wr_is_q) begin
          if (ctrl_reg_wr_strb[0]) weight_reg[wr_qi] <= ctrl_reg_wr_data[WEIGHT_WIDTH-1:0];
          if (ctrl_reg_wr_strb[2]) qen_reg[wr_qi] <= ctrl_reg_wr_data[16];
        end
      end
      if (ctrl_reg_rd_en && !rd_ack_reg && rd_hit) begin
        rd_ack_reg  <= 1'b1;
        rd_data_reg <= REG_DATA_WIDTH'(rd_val);
      end
    end
  end

  // Status is honoured only for tags that name a currently allocated slot
  assign deq_slot = s_axis_tx_status_dequeue_tag[OP_W-1:0];
  assign fin_slot = s_axis_tx_status_finish_tag[OP_W-1:0];
  assign deq_rel  = s_axis_tx_status_dequeue_valid && (s_axis_tx_status_dequeue_empty || s_axis_tx_status_dequeue_error)
                    && ((s_axis_tx_status_dequeue_tag >> OP_W) == '0) && op_valid[deq_slot];
  assign deq_clr  = deq_rel && s_axis_tx_status_dequeue_empty;
  assign deq_q    = op_queue[deq_slot];
  assign fin_rel  = s_axis_tx_status_finish_valid && ((s_axis_tx_status_finish_tag >> OP_W) == '0) && op_valid[fin_slot];

  always_comb begin
    free_found  = 1'b0;
    free_idx    = '0;
    outstanding = '0;
    for (int i = OP_TABLE_SIZE-1; i >= 0; i--) begin
      if (!op_valid[i]) begin
        free_found = 1'b1;
        free_idx   = OP_W'(i);
      end
      outstanding = outstanding + CNT_W'(op_valid[i]);
    end
  end

  assign eligible = active_reg & qen_reg;
  assign active   = (enable_reg && (|eligible)) || (outstanding != '0);

  // Stay on the pointer queue while credit lasts, else scan from pointer+1 (pointer itself last)
  always_comb begin
    issue       = 1'b0;
    load_credit = 1'b0;
    sel_q       = rr_ptr;
    if (enable_reg && free_found && (!req_valid || m_axis_tx_req_ready)) begin
      if (credit != '0 && eligible[rr_ptr]) begin
        issue = 1'b1;
      end else begin
        for (int i = QUEUE_COUNT; i >= 1; i--) begin
          if (eligible[QUEUE_INDEX_WIDTH'(int'(rr_ptr) + i)]) begin
            issue       = 1'b1;
            load_credit = 1'b1;
            sel_q       = QUEUE_INDEX_WIDTH'(int'(rr_ptr) + i);
          end
        end
      end
    end
  end

  assign sel_weight = weight_reg[sel_q];

  // Request handshake: payload loads only on issue, and issue requires the
  // register to be empty or accepted this cycle, so valid/payload hold until ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      req_valid     <= 1'b0;
      req_queue     <= '0;
      req_tag       <= '0;
      rr_ptr        <= '0;
      credit        <= '0;
      active_reg    <= '0;
      doorbell_seen <= '0;
      op_valid      <= '0;
      for (int i = 0; i < OP_TABLE_SIZE; i++) op_queue[i] <= '0;
    end else begin
      if (req_valid && m_axis_tx_req_ready) req_valid <= 1'b0;
      if (deq_rel) op_valid[deq_slot] <= 1'b0;
      if (fin_rel) op_valid[fin_slot] <= 1'b0;
      if (issue) begin
        req_valid               <= 1'b1;
        req_queue               <= sel_q;
        req_tag                 <= TX_REQ_TAG_WIDTH'(free_idx);
        rr_ptr                  <= sel_q;
        credit                  <= load_credit ? ((sel_weight == '0) ? '0 : sel_weight - WEIGHT_WIDTH'(1))
                                               : credit - WEIGHT_WIDTH'(1);
        op_valid[free_idx]      <= 1'b1;
        op_queue[free_idx]      <= sel_q;
        doorbell_seen[sel_q]    <= 1'b0;
      end
      if (deq_clr && !doorbell_seen[deq_q]) active_reg[deq_q] <= 1'b0;
      // A doorbell wins over a same-cycle empty status or issue
      if (s_axis_doorbell_valid) begin
        active_reg[s_axis_doorbell_queue]    <= 1'b1;
        doorbell_seen[s_axis_doorbell_queue] <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_mqnic_tx_scheduler_block_wrr.sv
// Directed bench for the WRR TX scheduler block: register map, issue order,
// op-table limits, back-pressure, activity tracking and enable gating.
module tb_mqnic_tx_scheduler_block_wrr;
  localparam int RW = 11;  // {queue[2:0], tag[7:0]}

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] ctrl_reg_wr_addr = '0;
  logic [31:0] ctrl_reg_wr_data = '0;
  logic [3:0]  ctrl_reg_wr_strb = '0;
  logic        ctrl_reg_wr_en = 1'b0;
  logic        ctrl_reg_wr_wait, ctrl_reg_wr_ack;
  logic [15:0] ctrl_reg_rd_addr = '0;
  logic        ctrl_reg_rd_en = 1'b0;
  logic [31:0] ctrl_reg_rd_data;
  logic        ctrl_reg_rd_wait, ctrl_reg_rd_ack;
  logic [2:0]  m_axis_tx_req_queue;
  logic [7:0]  m_axis_tx_req_tag;
  logic [3:0]  m_axis_tx_req_dest;
  logic        m_axis_tx_req_valid;
  logic        m_axis_tx_req_ready = 1'b0;
  logic        s_axis_tx_status_dequeue_empty = 1'b0;
  logic        s_axis_tx_status_dequeue_error = 1'b0;
  logic [7:0]  s_axis_tx_status_dequeue_tag = '0;
  logic        s_axis_tx_status_dequeue_valid = 1'b0;
  logic [7:0]  s_axis_tx_status_finish_tag = '0;
  logic        s_axis_tx_status_finish_valid = 1'b0;
  logic [2:0]  s_axis_doorbell_queue = '0;
  logic        s_axis_doorbell_valid = 1'b0;
  logic        active;

  int pass_cnt = 0;
  int fail_cnt = 0;
  int total_cnt = 0;
  logic [RW-1:0] exp_q[$];
  logic [RW-1:0] got_q[$];

  mqnic_tx_scheduler_block_wrr dut (
    .clk(clk), .rst(rst),
    .ctrl_reg_wr_addr(ctrl_reg_wr_addr), .ctrl_reg_wr_data(ctrl_reg_wr_data),
    .ctrl_reg_wr_strb(ctrl_reg_wr_strb), .ctrl_reg_wr_en(ctrl_reg_wr_en),
    .ctrl_reg_wr_wait(ctrl_reg_wr_wait), .ctrl_reg_wr_ack(ctrl_reg_wr_ack),
    .ctrl_reg_rd_addr(ctrl_reg_rd_addr), .ctrl_reg_rd_en(ctrl_reg_rd_en),
    .ctrl_reg_rd_data(ctrl_reg_rd_data), .ctrl_reg_rd_wait(ctrl_reg_rd_wait),
    .ctrl_reg_rd_ack(ctrl_reg_rd_ack),
    .m_axis_tx_req_queue(m_axis_tx_req_queue), .m_axis_tx_req_tag(m_axis_tx_req_tag),
    .m_axis_tx_req_dest(m_axis_tx_req_dest), .m_axis_tx_req_valid(m_axis_tx_req_valid),
    .m_axis_tx_req_ready(m_axis_tx_req_ready),
    .s_axis_tx_status_dequeue_empty(s_axis_tx_status_dequeue_empty),
    .s_axis_tx_status_dequeue_error(s_axis_tx_status_dequeue_error),
    .s_axis_tx_status_dequeue_tag(s_axis_tx_status_dequeue_tag),
    .s_axis_tx_status_dequeue_valid(s_axis_tx_status_dequeue_valid),
    .s_axis_tx_status_finish_tag(s_axis_tx_status_finish_tag),
    .s_axis_tx_status_finish_valid(s_axis_tx_status_finish_valid),
    .s_axis_doorbell_queue(s_axis_doorbell_queue), .s_axis_doorbell_valid(s_axis_doorbell_valid),
    .active(active)
  );

  // Clock / reset
  always #5 clk = ~clk;

  // Capture every accepted request mid-cycle, between input updates and the edge
  always @(negedge clk) begin
    if (!rst && m_axis_tx_req_valid && m_axis_tx_req_ready)
      got_q.push_back({m_axis_tx_req_queue, m_axis_tx_req_tag});
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", name, obs, exp);
    end
  endtask

  // Driver tasks
  task automatic reg_write(input logic [15:0] addr, input logic [31:0] data, input logic [3:0] strb);
    ctrl_reg_wr_addr = addr;
    ctrl_reg_wr_data = data;
    ctrl_reg_wr_strb = strb;
    ctrl_reg_wr_en   = 1'b1;
    cyc(1);
    check("wr_ack", 32'(ctrl_reg_wr_ack), 32'd1);
    ctrl_reg_wr_en = 1'b0;
    cyc(1);
  endtask

  task automatic check_read(input string name, input logic [15:0] addr, input logic [31:0] exp);
    logic [31:0] d;
    logic        a;
    ctrl_reg_rd_addr = addr;
    ctrl_reg_rd_en   = 1'b1;
    cyc(1);
    a = ctrl_reg_rd_ack;
    d = ctrl_reg_rd_data;
    ctrl_reg_rd_en = 1'b0;
    cyc(1);
    check({name, "_ack"}, 32'(a), 32'd1);
    check(name, d, exp);
  endtask

  task automatic doorbell(input logic [2:0] q);
    s_axis_doorbell_queue = q;
    s_axis_doorbell_valid = 1'b1;
    cyc(1);
    s_axis_doorbell_valid = 1'b0;
  endtask

  task automatic deq_empty(input logic [7:0] tag);
    s_axis_tx_status_dequeue_tag   = tag;
    s_axis_tx_status_dequeue_empty = 1'b1;
    s_axis_tx_status_dequeue_valid = 1'b1;
    cyc(1);
    s_axis_tx_status_dequeue_valid = 1'b0;
    s_axis_tx_status_dequeue_empty = 1'b0;
  endtask

  task automatic finish(input logic [7:0] tag);
    s_axis_tx_status_finish_tag   = tag;
    s_axis_tx_status_finish_valid = 1'b1;
    cyc(1);
    s_axis_tx_status_finish_valid = 1'b0;
  endtask

  task automatic release_all();
    for (int t = 0; t < 8; t++) deq_empty(8'(t));
  endtask

  task automatic push_exp(input logic [2:0] q, input logic [7:0] tag);
    exp_q.push_back({q, tag});
  endtask

  // Scoreboard: wait (bounded) for as many captured requests as expected, then compare in order
  task automatic compare_stream(input string name);
    int n;
    logic [RW-1:0] e, g;
    n = exp_q.size();
    for (int c = 0; c < 200 && got_q.size() < n; c++) cyc(1);
    check({name, "_count"}, 32'(got_q.size()), 32'(n));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = (got_q.size() > 0) ? got_q.pop_front() : '1;
      check(name, 32'(g), 32'(e));
    end
  endtask

  initial begin
    int stable;

    // Reset state and register map
    cyc(3);
    rst = 1'b0;
    check("rst_valid", 32'(m_axis_tx_req_valid), 32'd0);
    check("rst_qtag", {21'd0, m_axis_tx_req_queue, m_axis_tx_req_tag}, 32'd0);
    check("rst_acks", {30'd0, ctrl_reg_wr_ack, ctrl_reg_rd_ack}, 32'd0);
    check("rst_active", 32'(active), 32'd0);
    check_read("reg_type", 16'h00, 32'h0000_C004);
    check_read("reg_version", 16'h04, 32'h0000_0400);
    check_read("reg_qcount", 16'h1C, 32'd8);
    check_read("reg_dest", 16'h24, 32'h0);
    check_read("reg_bitmap0", 16'h2C, 32'h0);
    check_read("reg_q0_rst", 16'h40, 32'h0001_0001);
    ctrl_reg_rd_addr = 16'h30;
    ctrl_reg_rd_en   = 1'b1;
    cyc(1);
    check("unmapped_no_ack", 32'(ctrl_reg_rd_ack), 32'd0);
    ctrl_reg_rd_en = 1'b0;
    cyc(1);

    // Alternating q2/q5 with weight 1, latency N+2, table fills at 8
    m_axis_tx_req_ready = 1'b1;
    reg_write(16'h20, 32'h1, 4'hF);
    s_axis_doorbell_queue = 3'd2;
    s_axis_doorbell_valid = 1'b1;
    cyc(1);
    check("lat_n1_valid", 32'(m_axis_tx_req_valid), 32'd0);
    s_axis_doorbell_queue = 3'd5;
    cyc(1);
    s_axis_doorbell_valid = 1'b0;
    check("lat_n2_valid", 32'(m_axis_tx_req_valid), 32'd1);
    check("lat_n2_qtag", {21'd0, m_axis_tx_req_queue, m_axis_tx_req_tag}, {21'd0, 3'd2, 8'd0});
    for (int i = 0; i < 8; i++) push_exp((i % 2 == 0) ? 3'd2 : 3'd5, 8'(i));
    compare_stream("rr_q2_q5");
    cyc(4);
    check("full_valid_low", 32'(m_axis_tx_req_valid), 32'd0);
    check("full_no_extra", 32'(got_q.size()), 32'd0);
    check_read("outstanding_full", 16'h28, 32'd8);
    check_read("bitmap_q2_q5", 16'h2C, 32'h24);
    deq_empty(8'd1);
    push_exp(3'd2, 8'd1);
    compare_stream("q5_emptied");
    finish(8'd0);
    finish(8'd2);
    finish(8'd3);
    finish(8'd7);
    push_exp(3'd2, 8'd0);
    push_exp(3'd2, 8'd2);
    push_exp(3'd2, 8'd3);
    push_exp(3'd2, 8'd7);
    compare_stream("q2_only");
    check_read("bitmap_q2", 16'h2C, 32'h04);
    reg_write(16'h20, 32'h0, 4'hF);
    release_all();
    check_read("outstanding_drained", 16'h28, 32'd0);
    check_read("bitmap_drained", 16'h2C, 32'h0);
    check("idle_active", 32'(active), 32'd0);

    // Weights q0=3, q1=1
    reg_write(16'h40, 32'h0001_0003, 4'hF);
    doorbell(3'd0);
    doorbell(3'd1);
    reg_write(16'h20, 32'h1, 4'hF);
    push_exp(3'd0, 8'd0); push_exp(3'd0, 8'd1); push_exp(3'd0, 8'd2); push_exp(3'd1, 8'd3);
    push_exp(3'd0, 8'd4); push_exp(3'd0, 8'd5); push_exp(3'd0, 8'd6); push_exp(3'd1, 8'd7);
    compare_stream("wrr_3_1");
    check_read("q0_reg", 16'h40, 32'h0101_0003);
    reg_write(16'h20, 32'h0, 4'hF);
    release_all();

    // Back-pressure on q3, then table exhaustion and tag reuse
    m_axis_tx_req_ready = 1'b0;
    doorbell(3'd3);
    reg_write(16'h20, 32'h1, 4'hF);
    stable = 0;
    for (int i = 0; i < 20; i++) begin
      if (m_axis_tx_req_valid === 1'b1 && m_axis_tx_req_queue === 3'd3 && m_axis_tx_req_tag === 8'd0)
        stable++;
      cyc(1);
    end
    check("stall_stable_cycles", 32'(stable), 32'd20);
    check("stall_no_accept", 32'(got_q.size()), 32'd0);
    check_read("outstanding_stall", 16'h28, 32'd1);
    m_axis_tx_req_ready = 1'b1;
    for (int i = 0; i < 8; i++) push_exp(3'd3, 8'(i));
    compare_stream("q3_burst");
    cyc(4);
    check("q3_full_valid_low", 32'(m_axis_tx_req_valid), 32'd0);
    check("q3_no_extra", 32'(got_q.size()), 32'd0);
    finish(8'd5);
    push_exp(3'd3, 8'd5);
    compare_stream("q3_tag_reuse");
    reg_write(16'h20, 32'h0, 4'hF);
    release_all();

    // Doorbell and empty status for q4 in the same cycle
    m_axis_tx_req_ready = 1'b0;
    doorbell(3'd4);
    reg_write(16'h20, 32'h1, 4'hF);
    reg_write(16'h20, 32'h0, 4'hF);
    check("q4_pending", {20'd0, m_axis_tx_req_valid, m_axis_tx_req_queue, m_axis_tx_req_tag},
          {20'd0, 1'b1, 3'd4, 8'd0});
    m_axis_tx_req_ready = 1'b1;
    push_exp(3'd4, 8'd0);
    compare_stream("q4_first");
    s_axis_doorbell_queue          = 3'd4;
    s_axis_doorbell_valid          = 1'b1;
    s_axis_tx_status_dequeue_tag   = 8'd0;
    s_axis_tx_status_dequeue_empty = 1'b1;
    s_axis_tx_status_dequeue_valid = 1'b1;
    cyc(1);
    s_axis_doorbell_valid          = 1'b0;
    s_axis_tx_status_dequeue_valid = 1'b0;
    s_axis_tx_status_dequeue_empty = 1'b0;
    check_read("bitmap_q4_kept", 16'h2C, 32'h10);
    check_read("outstanding_q4_freed", 16'h28, 32'd0);

    // Enable cleared while a request is pending
    m_axis_tx_req_ready = 1'b0;
    reg_write(16'h20, 32'h1, 4'hF);
    check("q4_reissue", {20'd0, m_axis_tx_req_valid, m_axis_tx_req_queue, m_axis_tx_req_tag},
          {20'd0, 1'b1, 3'd4, 8'd0});
    reg_write(16'h20, 32'h0, 4'hF);
    cyc(3);
    check("disabled_valid_held", 32'(m_axis_tx_req_valid), 32'd1);
    m_axis_tx_req_ready = 1'b1;
    push_exp(3'd4, 8'd0);
    compare_stream("disabled_accept");
    cyc(5);
    check("disabled_no_more", 32'(got_q.size()), 32'd0);
    check("disabled_valid_low", 32'(m_axis_tx_req_valid), 32'd0);
    check_read("outstanding_one", 16'h28, 32'd1);
    check("active_outstanding", 32'(active), 32'd1);
    finish(8'd0);
    check_read("outstanding_zero", 16'h28, 32'd0);
    check("active_disabled", 32'(active), 32'd0);

    // Reset mid-operation
    m_axis_tx_req_ready = 1'b0;
    reg_write(16'h40, 32'h0001_0005, 4'hF);
    reg_write(16'h20, 32'h1, 4'hF);
    check("pre_reset_valid", 32'(m_axis_tx_req_valid), 32'd1);
    rst = 1'b1;
    cyc(2);
    rst = 1'b0;
    check("mid_rst_valid", 32'(m_axis_tx_req_valid), 32'd0);
    check("mid_rst_active", 32'(active), 32'd0);
    finish(8'd0);
    check_read("mid_rst_outstanding", 16'h28, 32'd0);
    check_read("mid_rst_enable", 16'h20, 32'd0);
    check_read("mid_rst_q0", 16'h40, 32'h0001_0001);

    // Final report
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
